mem_port_arbiter: RTL and testbench

- Shares one byte-wide, combinational-read program/data memory between two requesters: instruction fetch (port I) and data load (port D).
- Each accepted request is sequenced as N single-byte reads (N = 1, 2 or 4).
- The bytes are assembled big-endian, matching the CPU's memory byte order: byte at `addr` is most significant.
- The result is returned on a valid/ready response channel. Sits between the fetch/load units and the memory array.

---
 rtl/mem_arb_pkg.sv | 31 +++
 rtl/mem_port_arbiter_if.sv | 45 ++++
 rtl/mem_port_arbiter_rr_arb2.sv | 49 ++++
 rtl/mem_port_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the two-port byte-memory arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      RESP = 2'd2
   } state_e;

   typedef enum logic {
      PORT_I = 1'b0,
      PORT_D = 1'b1
   } port_e;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   // Response words are always 32 bits regardless of request size.
   localparam int RSP_W = 32;

   // Byte count for a load size; the reserved encoding reads a full word.
   function automatic logic [2:0] size_to_nbytes(input logic [1:0] sz);
      case (sz)
         SZ_BYTE: return 3'd1;
         SZ_HALF: return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response and memory-side signals of the arbiter, grouped as one bus.
interface mem_port_arbiter_if #(
   parameter int A_WIDTH = 32
);
   logic               i_req_valid;
   logic               i_req_ready;
   logic [A_WIDTH-1:0] i_req_addr;
   logic               i_rsp_valid;
   logic               i_rsp_ready;
   logic [31:0]        i_rsp_data;

   logic               d_req_valid;
   logic               d_req_ready;
   logic [A_WIDTH-1:0] d_req_addr;
   logic [1:0]         d_req_size;
   logic               d_rsp_valid;
   logic               d_rsp_ready;
   logic [31:0]        d_rsp_data;

   logic [A_WIDTH-1:0] mem_addr;
   logic               mem_en;
   logic [7:0]         mem_rdata;

   logic               busy;

   // Arbiter side.
   modport slave (
      input  i_req_valid, i_req_addr, i_rsp_ready,
      input  d_req_valid, d_req_addr, d_req_size, d_rsp_ready,
      input  mem_rdata,
      output i_req_ready, i_rsp_valid, i_rsp_data,
      output d_req_ready, d_rsp_valid, d_rsp_data,
      output mem_addr, mem_en, busy
   );

   // Requesters plus memory array side.
   modport master (
      output i_req_valid, i_req_addr, i_rsp_ready,
      output d_req_valid, d_req_addr, d_req_size, d_rsp_ready,
      output mem_rdata,
      input  i_req_ready, i_rsp_valid, i_rsp_data,
      input  d_req_ready, d_rsp_valid, d_rsp_data,
      input  mem_addr, mem_en, busy
   );
endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-requester round-robin grant; grants only while enabled, and a grant
// is itself the acceptance, so last-grant tracks accepted requests.
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic req_i,
   input  logic req_d,
   output logic gnt_i,
   output logic gnt_d
);

   port_e last_q, last_d;

   // Grant the requester that did not win last time when both ask.
   always_comb begin
      gnt_i = 1'b0;
      gnt_d = 1'b0;
      if (en) begin
         if (req_i && req_d) begin
            gnt_i = (last_q == PORT_D);
            gnt_d = (last_q == PORT_I);
         end else begin
            gnt_i = req_i;
            gnt_d = req_d;
         end
      end
   end

   // Remember who was accepted most recently.
   always_comb begin
      last_d = last_q;
      if (gnt_i)
         last_d = PORT_I;
      else if (gnt_d)
         last_d = PORT_D;
   end

   // Reset to D so fetch wins the first tie.
   always_ff @(posedge clk) begin
      if (rst)
         last_q <= PORT_D;
      else
         last_q <= last_d;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a byte-wide combinational-read memory between fetch (I) and load (D)
// ports, assembling 1/2/4 byte reads big-endian into a 32-bit response.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int A_WIDTH = 32,
   parameter int D_WIDTH = 8
) (
   input logic                clk,
   input logic                rst,
   mem_port_arbiter_if.slave  bus
);

   state_e             state_q, state_d;
   port_e              port_q,  port_d;
   logic [A_WIDTH-1:0] base_q,  base_d;
   logic [2:0]         n_q,     n_d;
   logic [2:0]         k_q,     k_d;
   logic [RSP_W-1:0]   asm_q,   asm_d;

   logic gnt_i, gnt_d;
   logic arb_en;

   // Reset also blocks grants so no ready is shown while held in reset.
   assign arb_en = (state_q == IDLE) && !rst;

   rr_arb2 u_arb (
      .clk   (clk),
      .rst   (rst),
      .en    (arb_en),
      .req_i (bus.i_req_valid),
      .req_d (bus.d_req_valid),
      .gnt_i (gnt_i),
      .gnt_d (gnt_d)
   );

   // Transaction sequencing: accept, read N bytes one per cycle, hold response.
   always_comb begin
      state_d = state_q;
      port_d  = port_q;
      base_d  = base_q;
      n_d     = n_q;
      k_d     = k_q;
      asm_d   = asm_q;
      case (state_q)
         IDLE: begin
            if (gnt_i) begin
               port_d  = PORT_I;
               base_d  = bus.i_req_addr;
               n_d     = 3'd4;
               k_d     = 3'd0;
               asm_d   = '0;
               state_d = READ;
            end else if (gnt_d) begin
               port_d  = PORT_D;
               base_d  = bus.d_req_addr;
               n_d     = size_to_nbytes(bus.d_req_size);
               k_d     = 3'd0;
               asm_d   = '0;
               state_d = READ;
            end
         end
         READ: begin
            // Shifting left puts the first byte read in the most significant
            // position; short reads stay right-aligned over the cleared word.
            asm_d = {asm_q[RSP_W-D_WIDTH-1:0], bus.mem_rdata};
            k_d   = k_q + 3'd1;
            if (k_d == n_q)
               state_d = RESP;
         end
         RESP: begin
            if ((port_q == PORT_I) ? bus.i_rsp_ready : bus.d_rsp_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are decoded from state so everything idles at zero.
   always_comb begin
      bus.i_req_ready = gnt_i;
      bus.d_req_ready = gnt_d;
      bus.i_rsp_valid = 1'b0;
      bus.i_rsp_data  = '0;
      bus.d_rsp_valid = 1'b0;
      bus.d_rsp_data  = '0;
      bus.mem_en      = 1'b0;
      bus.mem_addr    = '0;
      bus.busy        = (state_q != IDLE);
      case (state_q)
         READ: begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = base_q + A_WIDTH'(k_q);
         end
         RESP: begin
            if (port_q == PORT_I) begin
               bus.i_rsp_valid = 1'b1;
               bus.i_rsp_data  = asm_q;
            end else begin
               bus.d_rsp_valid = 1'b1;
               bus.d_rsp_data  = asm_q;
            end
         end
         default: ;
      endcase
   end

   // State register; reset drops any in-flight transaction.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         port_q  <= PORT_I;
         base_q  <= '0;
         n_q     <= 3'd0;
         k_q     <= 3'd0;
         asm_q   <= '0;
      end else begin
         state_q <= state_d;
         port_q  <= port_d;
         base_q  <= base_d;
         n_q     <= n_d;
         k_q     <= k_d;
         asm_q   <= asm_d;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a response scoreboard.
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.A_WIDTH(32)) bus();

   mem_port_arbiter #(.A_WIDTH(32), .D_WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Memory model: low 16 bytes and top 16 bytes of the address space.
   logic [7:0] mem_lo [0:15];
   logic [7:0] mem_hi [0:15];
   assign bus.mem_rdata = (bus.mem_addr[31:4] == 28'h0)       ? mem_lo[bus.mem_addr[3:0]] :
                          (bus.mem_addr[31:4] == 28'hFFFFFFF) ? mem_hi[bus.mem_addr[3:0]] : 8'h00;

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] exp_i[$];
   logic [31:0] exp_d[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: compare each completed response handshake against the queue.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.i_rsp_valid && bus.i_rsp_ready) begin
            n_cmp++;
            if (exp_i.size() == 0) begin
               n_err++;
               $display("FAIL i_rsp unexpected: got %h expected none", bus.i_rsp_data);
            end else begin
               n_cmp--;
               chk("i_rsp_data", bus.i_rsp_data, exp_i.pop_front());
            end
         end
         if (bus.d_rsp_valid && bus.d_rsp_ready) begin
            n_cmp++;
            if (exp_d.size() == 0) begin
               n_err++;
               $display("FAIL d_rsp unexpected: got %h expected none", bus.d_rsp_data);
            end else begin
               n_cmp--;
               chk("d_rsp_data", bus.d_rsp_data, exp_d.pop_front());
            end
         end
         if (bus.i_rsp_valid || bus.d_rsp_valid)
            chk("rsp_valid overlap", {31'd0, bus.i_rsp_valid & bus.d_rsp_valid}, 32'd0);
      end
   end

   task automatic wait_ready(input bit is_i, input string nm);
      int t = 0;
      @(negedge clk);
      while (!(is_i ? bus.i_req_ready : bus.d_req_ready) && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk(nm, {31'd0, is_i ? bus.i_req_ready : bus.d_req_ready}, 32'd1);
   endtask

   // Starts in the cycle right after the accept edge.
   task automatic read_seq(input logic [31:0] base, input int n, input bit is_i, input string nm);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         chk({nm, " mem_addr"}, bus.mem_addr, base + k);
         chk({nm, " mem_en"}, {31'd0, bus.mem_en}, 32'd1);
         chk({nm, " early rsp_valid"}, {31'd0, is_i ? bus.i_rsp_valid : bus.d_rsp_valid}, 32'd0);
         @(posedge clk);
      end
      @(negedge clk);
      chk({nm, " rsp_valid"}, {31'd0, is_i ? bus.i_rsp_valid : bus.d_rsp_valid}, 32'd1);
   endtask

   task automatic xfer(input bit is_i, input logic [31:0] addr, input logic [1:0] size,
                       input logic [31:0] exp, input string nm);
      int n;
      n = is_i ? 4 : (size == 2'd0 ? 1 : (size == 2'd1 ? 2 : 4));
      if (is_i) begin
         bus.i_req_valid = 1'b1;
         bus.i_req_addr  = addr;
      end else begin
         bus.d_req_valid = 1'b1;
         bus.d_req_addr  = addr;
         bus.d_req_size  = size;
      end
      wait_ready(is_i, {nm, " req_ready"});
      if (is_i) exp_i.push_back(exp);
      else      exp_d.push_back(exp);
      @(posedge clk); #1;
      bus.i_req_valid = 1'b0;
      bus.d_req_valid = 1'b0;
      read_seq(addr, n, is_i, nm);
      @(posedge clk); #1;
   endtask

   task automatic chk_idle_outputs(input string nm);
      chk({nm, " req_ready"}, {30'd0, bus.i_req_ready, bus.d_req_ready}, 32'd0);
      chk({nm, " rsp_valid"}, {30'd0, bus.i_rsp_valid, bus.d_rsp_valid}, 32'd0);
      chk({nm, " i_rsp_data"}, bus.i_rsp_data, 32'd0);
      chk({nm, " d_rsp_data"}, bus.d_rsp_data, 32'd0);
      chk({nm, " mem_addr"}, bus.mem_addr, 32'd0);
      chk({nm, " mem_en/busy"}, {30'd0, bus.mem_en, bus.busy}, 32'd0);
   endtask

   initial begin
      for (int a = 0; a < 16; a++) begin
         mem_lo[a] = 8'h00;
         mem_hi[a] = 8'h00;
      end
      mem_lo[0] = 8'h13; mem_lo[1] = 8'h05;
      mem_lo[5] = 8'h12; mem_lo[6] = 8'h34;
      mem_hi[14] = 8'hDE; mem_hi[15] = 8'hAD;

      rst = 1'b1;
      bus.i_req_valid = 1'b0; bus.i_req_addr = '0; bus.i_rsp_ready = 1'b1;
      bus.d_req_valid = 1'b0; bus.d_req_addr = '0; bus.d_req_size = 2'd0;
      bus.d_rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_idle_outputs("reset");
      @(posedge clk); #1;
      rst = 1'b0;

      // Basic word fetch, then byte/half/reserved-size loads.
      xfer(1'b1, 32'h0, 2'd0, 32'h13050000, "I word@0");
      mem_lo[2] = 8'hA7;
      xfer(1'b0, 32'h2, 2'd0, 32'h000000A7, "D byte@2");
      xfer(1'b0, 32'h5, 2'd1, 32'h00001234, "D half@5");
      xfer(1'b0, 32'h4, 2'd3, 32'h00123400, "D rsvd@4");
      xfer(1'b1, 32'hFFFFFFFE, 2'd0, 32'hDEAD1305, "I wrap");

      // Round-robin from reset with both ports persistently requesting.
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      bus.i_req_valid = 1'b1; bus.i_req_addr = 32'h0;
      bus.d_req_valid = 1'b1; bus.d_req_addr = 32'h2; bus.d_req_size = 2'd0;
      for (int g = 0; g < 4; g++) begin
         int t = 0;
         @(negedge clk);
         while (!(bus.i_req_ready || bus.d_req_ready) && t < 20) begin
            @(negedge clk);
            t++;
         end
         chk($sformatf("grant%0d i_req_ready", g), {31'd0, bus.i_req_ready}, {31'd0, (g % 2) == 0});
         chk($sformatf("grant%0d d_req_ready", g), {31'd0, bus.d_req_ready}, {31'd0, (g % 2) == 1});
         if (bus.i_req_ready) exp_i.push_back(32'h1305A700);
         if (bus.d_req_ready) exp_d.push_back(32'h000000A7);
         @(posedge clk); #1;
      end
      bus.i_req_valid = 1'b0;
      bus.d_req_valid = 1'b0;
      begin
         int t = 0;
         while ((bus.busy || exp_i.size() != 0 || exp_d.size() != 0) && t < 40) begin
            @(posedge clk); #1;
            t++;
         end
         chk("rr drain", {31'd0, bus.busy}, 32'd0);
      end

      // Consumer stall on I with D waiting; D goes next after release.
      bus.i_rsp_ready = 1'b0;
      bus.i_req_valid = 1'b1; bus.i_req_addr = 32'h0;
      bus.d_req_valid = 1'b1; bus.d_req_addr = 32'h2; bus.d_req_size = 2'd0;
      wait_ready(1'b1, "stall I req_ready");
      exp_i.push_back(32'h1305A700);
      @(posedge clk); #1;
      bus.i_req_valid = 1'b0;
      read_seq(32'h0, 4, 1'b1, "I stall");
      for (int c = 0; c < 5; c++) begin
         if (c > 0) @(negedge clk);
         chk($sformatf("stall%0d i_rsp_valid", c), {31'd0, bus.i_rsp_valid}, 32'd1);
         chk($sformatf("stall%0d i_rsp_data", c), bus.i_rsp_data, 32'h1305A700);
         chk($sformatf("stall%0d busy", c), {31'd0, bus.busy}, 32'd1);
         chk($sformatf("stall%0d d_req_ready", c), {31'd0, bus.d_req_ready}, 32'd0);
         @(posedge clk); #1;
      end
      bus.i_rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("post-stall busy", {31'd0, bus.busy}, 32'd0);
      chk("post-stall i_rsp_valid", {31'd0, bus.i_rsp_valid}, 32'd0);
      chk("post-stall d_req_ready", {31'd0, bus.d_req_ready}, 32'd1);
      exp_d.push_back(32'h000000A7);
      @(posedge clk); #1;
      bus.d_req_valid = 1'b0;
      read_seq(32'h2, 1, 1'b0, "D after stall");
      @(posedge clk); #1;

      // Reset in the middle of a read discards the transaction.
      bus.i_req_valid = 1'b1; bus.i_req_addr = 32'h0;
      wait_ready(1'b1, "abort I req_ready");
      @(posedge clk); #1;
      bus.i_req_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("abort k=2 mem_addr", bus.mem_addr, 32'h2);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk_idle_outputs("abort");
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk($sformatf("abort quiet%0d", c), {30'd0, bus.i_rsp_valid, bus.busy}, 32'd0);
      end
      @(posedge clk); #1;
      xfer(1'b1, 32'h0, 2'd0, 32'h1305A700, "I post-reset");

      repeat (2) @(posedge clk);
      chk("exp_i drained", exp_i.size(), 32'd0);
      chk("exp_d drained", exp_d.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
